// File: rtl/sram_chain_reader.sv
// sram_chain_reader: scans a bitcell chain one read wordline at a time and assembles the read word.
module sram_chain_reader #(
    parameter int NUM_CELLS = 8,
    parameter int SETTLE    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_clk,
    input  logic                 en_pwr,
    input  logic                 test_mode,
    input  logic                 start,
    input  logic                 rbl,
    input  logic                 ready,
    output logic [NUM_CELLS-1:0] rwl,
    output logic [NUM_CELLS-1:0] data,
    output logic                 valid,
    output logic                 busy,
    output logic                 aborted
);
    localparam int IW = NUM_CELLS > 1 ? $clog2(NUM_CELLS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_CELLS - 1);
    localparam logic [3:0] SET = 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t               state, state_d;
    logic [IW-1:0]        idx, idx_d;
    logic [3:0]           cnt, cnt_d;
    logic [NUM_CELLS-1:0] shadow, shadow_d, data_d;
    logic                 valid_d, aborted_d;
    logic                 run, pwr;

    assign run  = en_clk | test_mode;
    assign pwr  = en_pwr | test_mode;
    assign busy = state == READ;
    assign rwl  = (state == READ && pwr) ? NUM_CELLS'(1) << idx : '0;

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        cnt_d     = cnt;
        shadow_d  = shadow;
        data_d    = data;
        valid_d   = valid;
        aborted_d = run ? 1'b0 : aborted;
        if (run) begin
            case (state)
                IDLE: if (pwr && start) begin
                    state_d = READ;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                READ: if (!pwr) begin
                    state_d   = IDLE;
                    idx_d     = '0;
                    cnt_d     = '0;
                    shadow_d  = '0;
                    aborted_d = 1'b1;
                end else if (cnt != SET) begin
                    cnt_d = cnt + 1'b1;
                end else begin
                    // sample this cell and move the wordline on the same edge
                    shadow_d[idx] = rbl;
                    cnt_d         = '0;
                    if (idx == LAST) begin
                        data_d  = shadow_d;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
                DONE: if (ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            shadow  <= '0;
            data    <= '0;
            valid   <= 1'b0;
            aborted <= 1'b0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            cnt     <= cnt_d;
            shadow  <= shadow_d;
            data    <= data_d;
            valid   <= valid_d;
            aborted <= aborted_d;
        end
    end
endmodule

// File: tb/tb_sram_chain_reader.sv
// tb_sram_chain_reader: randomized scans of a modelled bitcell array checked against timing and data rules.
module tb_sram_chain_reader;
    localparam int N = 8;
    localparam int S = 1;
    localparam int SCAN = N * (S + 1);

    logic         clk, rst_n, en_clk, en_pwr, test_mode, start, rbl, ready;
    logic [N-1:0] rwl, data, mem, last;
    logic         valid, busy, aborted;
    int           n_chk, n_fail;

    sram_chain_reader #(.NUM_CELLS(N), .SETTLE(S)) dut (
        .clk(clk), .rst_n(rst_n), .en_clk(en_clk), .en_pwr(en_pwr),
        .test_mode(test_mode), .start(start), .rbl(rbl), .ready(ready),
        .rwl(rwl), .data(data), .valid(valid), .busy(busy), .aborted(aborted)
    );

    // the bitcell array drives the shared bitline from whichever cell is selected
    assign rbl = |(rwl & mem);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_scan(input logic [N-1:0] p);
        mem   = p;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // mode 0: no stalls, 1: random en_clk stalls, 2: 3-cycle stall in cell 3, 3: en_clk held low
    task automatic run_scan(input logic [N-1:0] p, input int mode, input int act0);
        int active = act0, cycles = 0, stalled = 0;
        while (active < SCAN && cycles < 200) begin
            check("rwl_walk", rwl, 32'(1) << (active / (S + 1)));
            check("busy_scan", busy, 1);
            check("valid_early", valid, 0);
            en_clk = mode == 3 ? 1'b0 :
                     mode == 1 ? ($urandom_range(0, 3) != 0) :
                     (mode == 2 && active == 3 * (S + 1) + 1 && stalled < 3) ? 1'b0 : 1'b1;
            if (!(en_clk | test_mode)) stalled++;
            step();
            cycles++;
            if (en_clk | test_mode) active++;
        end
        en_clk = 1'b1;
        check("valid_done", valid, 1);
        check("data_done", data, p);
        check("busy_done", busy, 0);
        check("rwl_done", rwl, 0);
        if (mode == 2) check("stall_len", cycles, SCAN + 3);
    endtask

    task automatic finish_scan();
        ready = 1'b1;
        step();
        check("valid_clr", valid, 0);
        check("busy_idle", busy, 0);
        ready = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rwl"}, rwl, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_aborted"}, aborted, 0);
    endtask

    initial begin
        logic [N-1:0] p;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b1; en_clk = 1'b1; en_pwr = 1'b1; test_mode = 1'b0;
        start = 1'b0; ready = 1'b0; mem = '0; last = '0;
        #2 rst_n = 1'b0;
        #2 check_zero("reset");
        step(); step();
        rst_n = 1'b1;
        step();

        // defaults, ready already high: valid after k+16, idle after k+17
        ready = 1'b1;
        start_scan(8'hA5);
        run_scan(8'hA5, 0, 0);
        step();
        check("ready_pre_valid", valid, 0);
        check("ready_pre_busy", busy, 0);
        check("ready_pre_data", data, 8'hA5);
        ready = 1'b0;
        last = 8'hA5;

        // consumer stalls five cycles; a start in DONE is ignored
        start_scan(8'h3C);
        run_scan(8'h3C, 0, 0);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            step();
            check("hold_valid", valid, 1);
            check("hold_data", data, 8'h3C);
            check("hold_busy", busy, 0);
        end
        start = 1'b0;
        finish_scan();
        step();
        check("no_start_in_done", busy, 0);
        last = 8'h3C;

        // clock-enable stall in cell 3
        start_scan(8'h96);
        run_scan(8'h96, 2, 0);
        finish_scan();
        last = 8'h96;

        // start held through the DONE-to-IDLE return is taken the edge after
        start_scan(8'h41);
        run_scan(8'h41, 0, 0);
        mem = 8'hC3;
        start = 1'b1; ready = 1'b1;
        step();
        check("ret_idle", busy, 0);
        check("ret_valid", valid, 0);
        ready = 1'b0;
        step();
        start = 1'b0;
        check("held_start", busy, 1);
        run_scan(8'hC3, 0, 0);
        finish_scan();
        last = 8'hC3;

        // random patterns, random stalls, random consumer delay
        for (int t = 0; t < 6; t++) begin
            p = N'($urandom);
            start_scan(p);
            run_scan(p, 1, 0);
            for (int d = $urandom_range(0, 3); d > 0; d--) begin
                step();
                check("rnd_hold", data, p);
            end
            finish_scan();
            last = p;
        end

        // power drop in cell 5 aborts and keeps the previous word
        start_scan(8'h5A);
        repeat (5 * (S + 1)) step();
        check("pre_drop_rwl", rwl, 8'h20);
        en_pwr = 1'b0;
        #1 check("drop_rwl", rwl, 0);
        step();
        check("abort_pulse", aborted, 1);
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        check("abort_data", data, last);
        step();
        check("abort_once", aborted, 0);
        en_pwr = 1'b1;
        start_scan(8'hE7);
        run_scan(8'hE7, 0, 0);
        finish_scan();
        last = 8'hE7;

        // power dips while the clock is disabled, then returns: scan resumes
        start_scan(8'h1B);
        repeat (4) step();
        en_clk = 1'b0; en_pwr = 1'b0;
        #1 check("frz_rwl", rwl, 0);
        step();
        check("frz_busy", busy, 1);
        check("frz_abort", aborted, 0);
        en_pwr = 1'b1;
        #1 check("resume_rwl", rwl, 8'h04);
        run_scan(8'h1B, 0, 4);
        finish_scan();
        last = 8'h1B;

        // test_mode overrides both enables
        test_mode = 1'b1; en_pwr = 1'b0;
        start_scan(8'hFF);
        run_scan(8'hFF, 3, 0);
        ready = 1'b1;
        en_clk = 1'b0;
        step();
        check("tm_idle", valid, 0);
        ready = 1'b0;
        test_mode = 1'b0; en_pwr = 1'b1; en_clk = 1'b1;

        // asynchronous reset mid-scan, then a clean scan from cell 0
        start_scan(8'h77);
        repeat (5) step();
        rst_n = 1'b0;
        #1 check_zero("mid_reset");
        step();
        rst_n = 1'b1;
        step();
        start_scan(8'h99);
        run_scan(8'h99, 0, 0);
        finish_scan();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
